// File: rtl/led_status_sequencer_pkg.sv
// Shared constants for the front-panel status LED sequencer.
package led_status_sequencer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  localparam int unsigned PULSE_W = 4;

  // 250 ms tick at a 100 MHz system clock
  localparam logic [31:0] DEFAULT_TICK_DIV = 32'd25_000_000;

endpackage

// File: rtl/led_status_sequencer_tick_gen.sv
// Free-running tick divider; held at zero while clr is high so each
// blink phase after clr drops lasts exactly TICK_DIV cycles.
module led_tick_gen
  import led_status_sequencer_pkg::*;
#(
  parameter logic [31:0] TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [31:0] TICK_LAST = TICK_DIV - 32'd1;

  logic [31:0] cnt;

  // >= rather than == so an out-of-range count recovers on its own
  assign tick = (cnt >= TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 32'd0;
    end else if (clr || tick) begin
      cnt <= 32'd0;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/led_status_sequencer.sv
// Round-robin sharing of one status LED: each granted requester gets its
// blink code (N on/off pulses) followed by an LED-off gap.
module led_status_sequencer
  import led_status_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter logic [31:0] TICK_DIV  = DEFAULT_TICK_DIV,
  parameter int unsigned GAP_TICKS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [PULSE_W*NUM_REQ-1:0]   pulses,
  output logic                         led,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         busy,
  output logic [NUM_REQ-1:0]           done
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned GAP_W = $clog2(GAP_TICKS + 1);

  logic [1:0]           state, state_n;
  logic [IDX_W-1:0]     last, last_n;
  logic [NUM_REQ-1:0]   grant_n, done_n;
  logic [PULSE_W-1:0]   remaining, remaining_n;
  logic [GAP_W-1:0]     gap_cnt, gap_n;
  logic                 led_n, busy_n;
  logic                 tick;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     cand;
  logic [PULSE_W-1:0]   win_pulses;

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == ST_IDLE),
    .tick (tick)
  );

  // Round-robin search starting just after the last winner
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((32'(last) + off) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_pulses = pulses[PULSE_W*win_idx +: PULSE_W];
  end

  always_comb begin
    state_n     = state;
    last_n      = last;
    grant_n     = grant;
    remaining_n = remaining;
    gap_n       = gap_cnt;
    done_n      = '0;
    case (state)
      ST_IDLE: begin
        if (win_found) begin
          state_n     = ST_ON;
          last_n      = win_idx;
          grant_n     = NUM_REQ'(1) << win_idx;
          remaining_n = (win_pulses == '0) ? PULSE_W'(1) : win_pulses;
        end
      end
      ST_ON: begin
        if (tick) state_n = ST_OFF;
      end
      ST_OFF: begin
        if (tick) begin
          if (remaining <= PULSE_W'(1)) begin
            state_n = ST_GAP;
            gap_n   = GAP_W'(GAP_TICKS);
          end else begin
            state_n     = ST_ON;
            remaining_n = remaining - PULSE_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          gap_n = gap_cnt - GAP_W'(1);
          if (gap_cnt <= GAP_W'(1)) begin
            state_n = ST_IDLE;
            grant_n = '0;
            done_n  = grant;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        grant_n = '0;
      end
    endcase
    led_n  = (state_n == ST_ON);
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      last      <= IDX_W'(NUM_REQ - 1);
      grant     <= '0;
      remaining <= '0;
      gap_cnt   <= '0;
      led       <= 1'b0;
      busy      <= 1'b0;
      done      <= '0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      grant     <= grant_n;
      remaining <= remaining_n;
      gap_cnt   <= gap_n;
      led       <= led_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: doc/led_status_sequencer.md
# led_status_sequencer

Shares the single front-panel status LED between several requesters by playing per-requester blink codes. Each requester holds a request and a 4-bit pulse count; a round-robin arbiter grants the LED, a tick-timed FSM plays N on/off pulses followed by an inter-code gap, and the grant is then released. It sits above the OTDR status logic (acquisition, laser, link, error flags) and drives the KC705 GPIO LED pin directly.

## Interface

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TICK_DIV, 32'd25_000_000, clk cycles per tick (250 ms at 100 MHz); must be ≥2.
- GAP_TICKS, 4, ticks of LED-off gap after each code; must be ≥1.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- req  input  NUM_REQ  level request per requester.
- pulses  input  4*NUM_REQ  pulse count per requester; requester i uses bits [4i+3:4i]; value 0 is played as 1.
- led  output  1  LED drive, registered.
- grant  output  NUM_REQ  one-hot, index currently being played; all zero in IDLE.
- busy  output  1  high in any state other than IDLE.
- done  output  NUM_REQ  one-cycle pulse on the bit of the requester whose code just completed.

## Operation

- States: IDLE, ON, OFF, GAP.
- IDLE: led=0, grant=0. If any req bit is set, choose the winner round-robin, searching indices last+1, last+2, … wrapping to last. Latch the winner index into last and into grant. Latch its pulse count into remaining, with 0 replaced by 1. Clear the tick counter. Go to ON.
- ON: led=1. On tick, go to OFF.
- OFF: led=0. On tick: if remaining==1, go to GAP and load the gap counter with GAP_TICKS; otherwise decrement remaining and go to ON.
- GAP: led=0. On tick, decrement the gap counter. When it reaches 0, go to IDLE, clear grant, and pulse the done bit for the granted index.
- Request sampling:
  - req and pulses are sampled only in IDLE.
  - Deasserting req, or changing pulses, during playback has no effect; the code always plays to completion.
- Tick generation:
  - The counter runs 0..TICK_DIV-1. tick is high on the cycle the count equals TICK_DIV-1; the count then wraps to 0.
  - The counter is cleared on IDLE exit, so every ON/OFF phase is exactly TICK_DIV cycles.
- Reset (asynchronous, takes effect without a clock edge):
  - state=IDLE, led=0, grant=0, busy=0, done=0, remaining=0, tick counter=0.
  - last=NUM_REQ-1, so index 0 wins first after reset.
  - Reset mid-playback abandons the code; no done pulse is generated.
- Width rules: remaining is 4 bits. The gap counter is $clog2(GAP_TICKS+1) bits. The tick counter is 32 bits and compares with ≥ against TICK_DIV-1 so it self-recovers.

## Timing

- Request seen in IDLE at cycle t: the ON state, led=1 and grant are all valid at t+1.
- Code of P pulses occupies cycles t+1 .. t+(2P+GAP_TICKS)·TICK_DIV.
- The done pulse is asserted in the following cycle, the first IDLE cycle. That same cycle arbitrates, so a back-to-back code starts one cycle later.
- busy equals (state≠IDLE), registered with state.
- Simultaneous requests resolve in one IDLE cycle; the round-robin guarantees each active requester is served within NUM_REQ codes.

## Structure

- The shared package holds:
  - state encoding localparams: IDLE=0, ON=1, OFF=2, GAP=3;
  - PULSE_W=4;
  - the default TICK_DIV for 100 MHz.
- Sub-module led_tick_gen (parameter TICK_DIV; ports clk, rst, clr, tick) generates tick. The arbiter, FSM and counters stay in the top module.

## Test plan

All scenarios use TICK_DIV=4 and GAP_TICKS=2.
- req=4'b0001, pulses[3:0]=3, raised at cycle 0:
  - led high in cycles 1–4, 9–12, 17–20; low in 5–8, 13–16, 21–32;
  - done[0] pulses in cycle 33; grant=4'b0001 and busy=1 throughout 1–32.
- pulses[3:0]=0 on req0: exactly one high phase of 4 cycles, then 12 low cycles, then done[0].
- req=4'b0101 held continuously: grant sequence 0001, 0100, 0001, 0100; each new code starts 1 cycle after the previous done.
- req0 dropped, and pulses changed to 7, in cycle 6 of a 2-pulse code: 2 pulses still played; done[0] fires at cycle 25.
- rst asserted asynchronously mid-ON:
  - led, grant and busy go to 0 before the next clk edge; no done pulse;
  - after release with req=4'b1001, index 0 is granted first.
- All four req bits raised together: grants follow 0,1,2,3,0; no requester is skipped or played twice in a row.
